// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin between
// the pipeline (req0) and the long-latency unit (req1), pending-write scoreboard and RAW hazard flags.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DROP_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] chk_reg1,
  input  logic [ADDR_W-1:0] chk_reg2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData
);

  localparam int NREGS = 2 ** ADDR_W;

  // last_grant_q: 1 means req1 was granted last, so req0 wins the next tie
  logic              last_grant_q, last_grant_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              grant0, grant1;

  function automatic logic is_dropped(input logic [ADDR_W-1:0] r);
    return (DROP_R0 != 0) && (r == '0);
  endfunction

  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign issue_ready = is_dropped(issue_reg) || !pending_q[issue_reg];

  assign hazard1 = !is_dropped(chk_reg1) &&
                   (pending_q[chk_reg1] || (regwrite_q && (wreg_q == chk_reg1)));
  assign hazard2 = !is_dropped(chk_reg2) &&
                   (pending_q[chk_reg2] || (regwrite_q && (wreg_q == chk_reg2)));

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

  always_comb begin
    last_grant_d = last_grant_q;
    pending_d    = pending_q;
    regwrite_d   = 1'b0;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;

    if (grant0) begin
      last_grant_d = 1'b0;
      if (!is_dropped(req0_reg)) begin
        regwrite_d = 1'b1;
        wreg_d     = req0_reg;
        wdata_d    = req0_data;
      end
    end else if (grant1) begin
      last_grant_d        = 1'b1;
      pending_d[req1_reg] = 1'b0;
      if (!is_dropped(req1_reg)) begin
        regwrite_d = 1'b1;
        wreg_d     = req1_reg;
        wdata_d    = req1_data;
      end
    end

    // Applied after the clear so a same-cycle issue to the retiring register stays pending
    if (issue_valid && issue_ready && !is_dropped(issue_reg)) begin
      pending_d[issue_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      pending_q    <= '0;
      regwrite_q   <= 1'b0;
      wreg_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      regwrite_q   <= regwrite_d;
      wreg_q       <= wreg_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a rule-level model checked every cycle
// plus hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, issue_valid;
  logic [4:0]  req0_reg, req1_reg, issue_reg, chk_reg1, chk_reg2;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, issue_ready, hazard1, hazard2;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .hazard1(hazard1), .hazard2(hazard2),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which requester wins, which registers await a long-op result,
  // and what the register file sees one cycle after a grant.
  bit          m_valid = 0;
  int          m_last;
  bit          m_pend [32];
  bit          m_we;
  int          m_wreg;
  logic [31:0] m_wdata;
  bit          m_wknown;

  function automatic int winner(input logic v0, input logic v1, input int last);
    if (v0 && v1) return (last == 1) ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic bit exp_hazard(input int r);
    if (r == 0) return 0;
    return m_pend[r] || (m_we && m_wreg == r);
  endfunction

  always @(posedge clk) begin
    int w, r;
    if (reset) begin
      m_valid  = 1;
      m_last   = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_we     = 0;
      m_wreg   = 0;
      m_wdata  = 0;
      m_wknown = 1;
    end else if (m_valid) begin
      w    = winner(req0_valid, req1_valid, m_last);
      m_we = 0;
      if (w >= 0) begin
        m_last = w;
        r = (w == 0) ? int'(req0_reg) : int'(req1_reg);
        if (r == 0) m_wknown = 0;
        else begin
          m_we     = 1;
          m_wreg   = r;
          m_wdata  = (w == 0) ? req0_data : req1_data;
          m_wknown = 1;
        end
        if (w == 1) m_pend[r] = 0;
      end
      if (issue_valid && issue_reg != 0 && !m_pend[issue_reg]) m_pend[issue_reg] = 1;
    end
  end

  always @(negedge clk) begin
    int w;
    if (m_valid) begin
      w = winner(req0_valid, req1_valid, m_last);
      check("m_req0_ready", 32'(req0_ready), 32'(w == 0));
      check("m_req1_ready", 32'(req1_ready), 32'(w == 1));
      check("m_issue_ready", 32'(issue_ready), 32'(issue_reg == 0 || !m_pend[issue_reg]));
      check("m_hazard1", 32'(hazard1), 32'(exp_hazard(int'(chk_reg1))));
      check("m_hazard2", 32'(hazard2), 32'(exp_hazard(int'(chk_reg2))));
      check("m_RegWrite", 32'(RegWrite), 32'(m_we));
      if (m_wknown) begin
        check("m_WriteRegister", 32'(WriteRegister), 32'(m_wreg));
        check("m_WriteData", WriteData, m_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 0; req0_reg = 0; req0_data = 0;
    req1_valid = 0; req1_reg = 0; req1_data = 0;
    issue_valid = 0; issue_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_RegWrite", 32'(RegWrite), 32'd0);
    check("reset_WriteRegister", 32'(WriteRegister), 32'd0);
    check("reset_WriteData", WriteData, 32'd0);

    // single req0 write
    tick();
    req0_valid = 1; req0_reg = 8; req0_data = 32'hDEADBEEF;
    @(negedge clk);
    check("w8_ready", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 0;
    @(negedge clk);
    check("w8_RegWrite", 32'(RegWrite), 32'd1);
    check("w8_WriteRegister", 32'(WriteRegister), 32'd8);
    check("w8_WriteData", WriteData, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("w8_RegWrite_after", 32'(RegWrite), 32'd0);

    // round-robin tie after reset: req0, req1, req0, req1
    do_reset();
    req0_valid = 1; req0_reg = 9;  req0_data = 32'h9;
    req1_valid = 1; req1_reg = 10; req1_data = 32'hA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
      check("rr_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
      tick();
    end
    req0_valid = 0; req1_valid = 0;

    // scoreboard: issue 11, duplicate issue refused, req1 retires it
    issue_valid = 1; issue_reg = 11; chk_reg1 = 11;
    @(negedge clk);
    check("iss11_ready", 32'(issue_ready), 32'd1);
    tick();
    @(negedge clk);
    check("iss11_hazard", 32'(hazard1), 32'd1);
    check("iss11_dup_ready", 32'(issue_ready), 32'd0);
    tick();
    issue_valid = 0;
    req1_valid = 1; req1_reg = 11; req1_data = 32'h5;
    @(negedge clk);
    check("wb11_ready", 32'(req1_ready), 32'd1);
    check("wb11_hazard_grant", 32'(hazard1), 32'd1);
    tick();
    req1_valid = 0;
    @(negedge clk);
    check("wb11_RegWrite", 32'(RegWrite), 32'd1);
    check("wb11_WriteData", WriteData, 32'h5);
    check("wb11_hazard_inflight", 32'(hazard1), 32'd1);
    tick();
    @(negedge clk);
    check("wb11_hazard_clear", 32'(hazard1), 32'd0);
    check("wb11_issue_ready", 32'(issue_ready), 32'd1);

    // same-cycle retire and issue of reg 13: set wins
    tick();
    req1_valid = 1; req1_reg = 13; req1_data = 32'h13;
    issue_valid = 1; issue_reg = 13; chk_reg2 = 13;
    @(negedge clk);
    check("r13_req1_ready", 32'(req1_ready), 32'd1);
    check("r13_issue_ready", 32'(issue_ready), 32'd1);
    check("r13_hazard_same", 32'(hazard2), 32'd0);
    tick();
    req1_valid = 0; issue_valid = 0;
    @(negedge clk);
    check("r13_hazard_next", 32'(hazard2), 32'd1);
    tick();
    @(negedge clk);
    check("r13_hazard_pending", 32'(hazard2), 32'd1);
    check("r13_issue_busy", 32'(issue_ready), 32'd0);

    // register 0 is accepted and dropped
    tick();
    req0_valid = 1; req0_reg = 0; req0_data = 32'h1234;
    issue_valid = 1; issue_reg = 0; chk_reg1 = 0;
    @(negedge clk);
    check("r0_ready", 32'(req0_ready), 32'd1);
    check("r0_issue_ready", 32'(issue_ready), 32'd1);
    check("r0_hazard", 32'(hazard1), 32'd0);
    tick();
    req0_valid = 0; issue_valid = 0;
    @(negedge clk);
    check("r0_RegWrite", 32'(RegWrite), 32'd0);
    check("r0_hazard_after", 32'(hazard1), 32'd0);
    check("r0_issue_after", 32'(issue_ready), 32'd1);

    // reset mid-operation drops the in-flight write and the scoreboard
    tick();
    issue_valid = 1; issue_reg = 9; chk_reg1 = 9;
    tick();
    issue_valid = 0;
    req0_valid = 1; req0_reg = 8; req0_data = 32'hAA;
    @(negedge clk);
    check("rst_pending9", 32'(hazard1), 32'd1);
    tick();
    req0_valid = 0; reset = 1;
    @(negedge clk);
    check("rst_inflight", 32'(RegWrite), 32'd1);
    tick();
    reset = 0;
    @(negedge clk);
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_WriteRegister", 32'(WriteRegister), 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_hazard9", 32'(hazard1), 32'd0);
    tick();
    req0_valid = 1; req0_reg = 3; req0_data = 32'h33;
    req1_valid = 1; req1_reg = 4; req1_data = 32'h44;
    @(negedge clk);
    check("rst_tie_req0", 32'(req0_ready), 32'd1);
    check("rst_tie_req1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 register file between two write-back requesters: req0 (ALU/load pipeline WB) and req1 (long-latency unit, e.g. mult/div).
- Holds a pending-write scoreboard, set at long-op issue and cleared when the result is written.
- Supplies read-after-write hazard flags for the two read-port addresses so decode can stall.
- Sits between the WB stage, the long-latency unit and the register file's RegWrite/WriteRegister/WriteData inputs.

Parameters:
- DATA_W, 32: write data width.
- ADDR_W, 5: register index width; register count NREGS = 2**ADDR_W.
- DROP_R0, 1: when 1, writes to register 0 are accepted and discarded.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  WB request from the pipeline.
- req0_reg  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req0_ready  out  1  req0 granted this cycle.
- req1_valid  in  1  WB request from the long-latency unit.
- req1_reg  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write data.
- req1_ready  out  1  req1 granted this cycle.
- issue_valid  in  1  long op issued; marks issue_reg pending.
- issue_reg  in  ADDR_W  destination of the issued long op.
- issue_ready  out  1  issue accepted: issue_reg is not already pending.
- chk_reg1  in  ADDR_W  read-port-1 address to check.
- chk_reg2  in  ADDR_W  read-port-2 address to check.
- hazard1  out  1  chk_reg1 has a pending or in-flight write.
- hazard2  out  1  chk_reg2 has a pending or in-flight write.
- RegWrite  out  1  register file write enable (registered).
- WriteRegister  out  ADDR_W  register file write address (registered).
- WriteData  out  DATA_W  register file write data (registered).

Behaviour:
- Handshake: a transfer occurs when valid && ready in the same cycle. Ready is combinational from valid and the arbiter state. Requesters hold reg/data stable while valid && !ready.
- Arbitration: round-robin with a 1-bit last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - last_grant updates only on a grant. At most one ready per cycle.
- Write issue: a grant in cycle N registers RegWrite=1 plus reg/data, visible in cycle N+1; the register file commits at the end of N+1. Fixed 1-cycle latency.
- No grant in cycle N: RegWrite=0 in N+1; WriteRegister/WriteData hold their last values.
- Register 0 (DROP_R0=1): a request to reg 0 is still granted (ready=1) but RegWrite stays 0 for it, and last_grant still updates.
- Scoreboard: pending[NREGS-1:0].
  - issue_ready = !pending[issue_reg]. Issue of reg 0 is always ready when DROP_R0=1 and does not set a bit.
  - issue_valid && issue_ready sets pending[issue_reg]; issue_valid && !issue_ready is ignored with no state change.
  - A req1 grant clears pending[req1_reg]. req0 grants never touch pending.
  - Set and clear of the same register in one cycle: set wins.
- Hazards (combinational): hazardK = pending[chk_regK] | (RegWrite && WriteRegister==chk_regK). A same-cycle req0/req1 grant to that register does not raise a hazard until the next cycle. chk_reg = 0 with DROP_R0=1 gives 0.
- Reset, whether idle or mid-operation, takes effect at the clock edge. In the next cycle:
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - pending all 0, last_grant = req1, so req0 wins the first tie.
  - The in-flight write is dropped.
- Ready outputs are combinational and may be nonzero during a cycle in which reset is asserted; grants in that cycle are discarded.

Test Plan:
- Reset, then req0_valid=1, req0_reg=8, req0_data=0xDEADBEEF for one cycle → req0_ready=1 that cycle; next cycle RegWrite=1, WriteRegister=8, WriteData=0xDEADBEEF; the cycle after, RegWrite=0.
- req0 and req1 both valid for 4 cycles (reg 9 and reg 10) → grants alternate req0, req1, req0, req1 after reset; never both ready in one cycle.
- issue reg 11 → next cycle hazard1=1 with chk_reg1=11. A second issue to reg 11 gives issue_ready=0. req1 writes reg 11 with 0x5 → hazard stays 1 through the RegWrite cycle, then 0; issue_ready for reg 11 returns to 1.
- Same cycle: req1 granted for reg 13 and issue_valid for reg 13 (with pending[13] previously clear) → pending[13]=1 afterwards (set wins); hazard on 13 stays asserted.
- req0 writes reg 0 with 0x1234 → req0_ready=1 and RegWrite stays 0; issue reg 0 leaves pending unchanged; hazard1 with chk_reg1=0 is 0.
- Grant req0 to reg 8 in cycle N, assert reset in cycle N+1 with pending[9]=1 → in cycle N+2 RegWrite=0, WriteRegister=0, WriteData=0 and hazard on 9 clear; the next simultaneous req0/req1 tie grants req0.
